rom_download_router: RTL and testbench

//  Single-clock ROM download front end: takes the ioctl byte stream (index 0) during load and

---
 rtl/xain_pkg.sv | 26 ++
 rtl/rdl_addr_decode.sv | 35 +++
 rtl/rom_download_router.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_rom_download_router.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xain_pkg.sv
// rtl/xain_pkg.sv - shared constants and types for the ROM download router
// Memory map: SDRAM region [0, SDR_END), BRAM region BRAM_CHIPS chips of
// BRAM_CHIP_BYTES each starting at BRAM_START; everything else is out of map.
package xain_pkg;

    localparam logic [24:0] SDR_END         = 25'h0100000;
    localparam logic [24:0] BRAM_START      = 25'h0100000;
    localparam logic [24:0] BRAM_CHIP_BYTES = 25'h0008000;
    localparam int          BRAM_CHIPS      = 6;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT_RDY,
        FLUSH,
        DONE
    } rdl_state_t;

    typedef enum logic [1:0] {
        RG_SDR,
        RG_BRAM,
        RG_NONE
    } rdl_region_t;

endpackage

// File: rtl/rdl_addr_decode.sv
// rtl/rdl_addr_decode.sv - combinational ioctl address decoder
// Ports:
//   addr     in  25  ioctl byte offset
//   region   out     RG_SDR / RG_BRAM / RG_NONE
//   chip_cs  out 6   one-hot BRAM chip select (zero unless RG_BRAM)
//   chip_off out 20  byte offset within the selected chip
module rdl_addr_decode
    import xain_pkg::*;
(
    input  logic [24:0]  addr,
    output rdl_region_t  region,
    output logic [5:0]   chip_cs,
    output logic [19:0]  chip_off
);

    logic [24:0] rel;
    logic [24:0] idx;
    logic [24:0] rem;

    always_comb begin
        rel      = addr - BRAM_START;
        idx      = rel / BRAM_CHIP_BYTES;
        rem      = rel % BRAM_CHIP_BYTES;
        region   = RG_NONE;
        chip_cs  = 6'b000000;
        chip_off = 20'(rem);
        if (addr < SDR_END) begin
            region = RG_SDR;
        end else if ((addr >= BRAM_START) && (idx < 25'(BRAM_CHIPS))) begin
            region  = RG_BRAM;
            chip_cs = 6'b000001 << idx;
        end
    end

endmodule

// File: rtl/rom_download_router.sv
// rtl/rom_download_router.sv - routes the ioctl ROM stream to SDRAM words and BRAM bytes
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/data  byte stream in; ioctl_wait throttles it
//   sdr_addr/data/be/req, sdr_rdy   SDRAM ch3 write port (req held until rdy)
//   bram_addr/data/cs/wr            BRAM byte write port (registered)
//   busy, load_done                 status; load_done pulses in DONE
//   err_overflow, err_timeout       sticky errors, cleared on reset or download rise
//   checksum                        byte sum when ROM_CHECKSUM_EN is defined, else 0
// Optional feature macro: ROM_CHECKSUM_EN
module rom_download_router
    import xain_pkg::*;
#(
    parameter logic [24:0] SDR_BASE    = 25'h0000000,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [15:0] ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [24:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        sdr_req,
    input  logic        sdr_rdy,
    output logic [19:0] bram_addr,
    output logic [7:0]  bram_data,
    output logic [5:0]  bram_cs,
    output logic        bram_wr,
    output logic        busy,
    output logic        load_done,
    output logic        err_overflow,
    output logic        err_timeout,
    output logic [15:0] checksum
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    rdl_state_t       state_q, state_d;
    logic             dl_q;
    logic             lo_vld_q, lo_vld_d;
    logic [7:0]       lo_q, lo_d;
    logic [23:0]      word_addr_q, word_addr_d;
    logic             skid_vld_q, skid_vld_d;
    logic [24:0]      skid_addr_q, skid_addr_d;
    logic [7:0]       skid_data_q, skid_data_d;
    logic             req_q, req_d;
    logic [24:0]      sdr_addr_q, sdr_addr_d;
    logic [15:0]      sdr_data_q, sdr_data_d;
    logic [1:0]       sdr_be_q, sdr_be_d;
    logic             bram_wr_q, bram_wr_d;
    logic [5:0]       bram_cs_q, bram_cs_d;
    logic [19:0]      bram_addr_q, bram_addr_d;
    logic [7:0]       bram_data_q, bram_data_d;
    logic             wait_q, wait_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        acc;
    logic        rise;
    logic [24:0] cur_addr;
    logic [7:0]  cur_data;
    rdl_region_t cur_region;
    logic [5:0]  cur_cs;
    logic [19:0] cur_off;
    logic        same_word;
    logic        take;
    logic        commit;

    assign acc  = ioctl_wr && (ioctl_index == 16'h0000) && ioctl_download;
    assign rise = ioctl_download && !dl_q;

    // A byte parked in the skid is always older than anything on the bus.
    assign cur_addr = skid_vld_q ? skid_addr_q : ioctl_addr;
    assign cur_data = skid_vld_q ? skid_data_q : ioctl_data;

    rdl_addr_decode u_decode (
        .addr     (cur_addr),
        .region   (cur_region),
        .chip_cs  (cur_cs),
        .chip_off (cur_off)
    );

    assign same_word = (cur_region == RG_SDR) && (cur_addr[24:1] == word_addr_q);
    assign take      = (state_q == COLLECT) && (skid_vld_q || acc);
    // A pending half word must leave before a byte from another word/region lands.
    assign commit    = take && !(lo_vld_q && !same_word);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dl_q        <= 1'b0;
            lo_vld_q    <= 1'b0;
            lo_q        <= 8'h00;
            word_addr_q <= 24'h000000;
            skid_vld_q  <= 1'b0;
            skid_addr_q <= 25'h0000000;
            skid_data_q <= 8'h00;
            req_q       <= 1'b0;
            sdr_addr_q  <= 25'h0000000;
            sdr_data_q  <= 16'h0000;
            sdr_be_q    <= 2'b00;
            bram_wr_q   <= 1'b0;
            bram_cs_q   <= 6'b000000;
            bram_addr_q <= 20'h00000;
            bram_data_q <= 8'h00;
            wait_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            dl_q        <= ioctl_download;
            lo_vld_q    <= lo_vld_d;
            lo_q        <= lo_d;
            word_addr_q <= word_addr_d;
            skid_vld_q  <= skid_vld_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
            req_q       <= req_d;
            sdr_addr_q  <= sdr_addr_d;
            sdr_data_q  <= sdr_data_d;
            sdr_be_q    <= sdr_be_d;
            bram_wr_q   <= bram_wr_d;
            bram_cs_q   <= bram_cs_d;
            bram_addr_q <= bram_addr_d;
            bram_data_q <= bram_data_d;
            wait_q      <= wait_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lo_vld_d    = lo_vld_q;
        lo_d        = lo_q;
        word_addr_d = word_addr_q;
        skid_vld_d  = skid_vld_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        req_d       = req_q;
        sdr_addr_d  = sdr_addr_q;
        sdr_data_d  = sdr_data_q;
        sdr_be_d    = sdr_be_q;
        bram_wr_d   = 1'b0;
        bram_cs_d   = 6'b000000;
        bram_addr_d = bram_addr_q;
        bram_data_d = bram_data_q;
        ovf_d       = ovf_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;

        if (rise) begin
            ovf_d = 1'b0;
            tmo_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rise) state_d = COLLECT;
            end
            COLLECT: begin
                if (take) begin
                    // Source ignored a full skid: the bus byte is lost.
                    if (skid_vld_q && acc) ovf_d = 1'b1;
                    if (!commit) begin
                        skid_vld_d  = 1'b1;
                        skid_addr_d = cur_addr;
                        skid_data_d = cur_data;
                        sdr_addr_d  = SDR_BASE + {word_addr_q, 1'b0};
                        sdr_data_d  = {8'h00, lo_q};
                        sdr_be_d    = 2'b01;
                        lo_vld_d    = 1'b0;
                        state_d     = ISSUE;
                    end else begin
                        skid_vld_d = 1'b0;
                        case (cur_region)
                            RG_SDR: begin
                                if (cur_addr[0]) begin
                                    // Odd byte always closes its word.
                                    sdr_addr_d = SDR_BASE + {cur_addr[24:1], 1'b0};
                                    sdr_data_d = {cur_data, lo_vld_q ? lo_q : 8'h00};
                                    sdr_be_d   = {1'b1, lo_vld_q};
                                    lo_vld_d   = 1'b0;
                                    state_d    = ISSUE;
                                end else begin
                                    lo_d        = cur_data;
                                    lo_vld_d    = 1'b1;
                                    word_addr_d = cur_addr[24:1];
                                end
                            end
                            RG_BRAM: begin
                                bram_wr_d   = 1'b1;
                                bram_cs_d   = cur_cs;
                                bram_addr_d = cur_off;
                                bram_data_d = cur_data;
                            end
                            default: ovf_d = 1'b1;
                        endcase
                    end
                end else if (!ioctl_download) begin
                    if (lo_vld_q) begin
                        sdr_addr_d = SDR_BASE + {word_addr_q, 1'b0};
                        sdr_data_d = {8'h00, lo_q};
                        sdr_be_d   = 2'b01;
                        lo_vld_d   = 1'b0;
                        state_d    = FLUSH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (sdr_rdy) begin
                    req_d   = 1'b0;
                    state_d = COLLECT;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = COLLECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                // First FLUSH cycle raises req; later cycles wait for the commit.
                if (!req_q) begin
                    req_d = 1'b1;
                    cnt_d = '0;
                end else if (sdr_rdy) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes arriving while throttled land in the skid, or are lost if it is full.
        if ((state_q == ISSUE) || (state_q == WAIT_RDY) || (state_q == FLUSH)) begin
            if (acc) begin
                if (skid_vld_q) begin
                    ovf_d = 1'b1;
                end else begin
                    skid_vld_d  = 1'b1;
                    skid_addr_d = ioctl_addr;
                    skid_data_d = ioctl_data;
                end
            end
        end

        wait_d = (state_d == ISSUE) || (state_d == WAIT_RDY) || (state_d == FLUSH) || skid_vld_d;
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || rise) begin
            sum_q <= 16'h0000;
        end else if (commit && (cur_region != RG_NONE)) begin
            sum_q <= sum_q + {8'h00, cur_data};
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign ioctl_wait   = wait_q;
    assign sdr_addr     = sdr_addr_q;
    assign sdr_data     = sdr_data_q;
    assign sdr_be       = sdr_be_q;
    assign sdr_req      = req_q;
    assign bram_addr    = bram_addr_q;
    assign bram_data    = bram_data_q;
    assign bram_cs      = bram_cs_q;
    assign bram_wr      = bram_wr_q;
    assign busy         = (state_q != IDLE);
    assign load_done    = (state_q == DONE);
    assign err_overflow = ovf_q;
    assign err_timeout  = tmo_q;

endmodule

// File: tb/tb_rom_download_router.sv
// tb/tb_rom_download_router.sv - directed self-checking bench for rom_download_router
module tb_rom_download_router;
    import xain_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [15:0] ioctl_index = 16'h0000;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'h0;
    logic [7:0]  ioctl_data = 8'h00;
    logic        ioctl_wait;
    logic [24:0] sdr_addr;
    logic [15:0] sdr_data;
    logic [1:0]  sdr_be;
    logic        sdr_req;
    logic        sdr_rdy = 1'b0;
    logic [19:0] bram_addr;
    logic [7:0]  bram_data;
    logic [5:0]  bram_cs;
    logic        bram_wr;
    logic        busy;
    logic        load_done;
    logic        err_overflow;
    logic        err_timeout;
    logic [15:0] checksum;

    int n_cmp = 0;
    int n_bad = 0;

    rom_download_router dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .sdr_addr       (sdr_addr),
        .sdr_data       (sdr_data),
        .sdr_be         (sdr_be),
        .sdr_req        (sdr_req),
        .sdr_rdy        (sdr_rdy),
        .bram_addr      (bram_addr),
        .bram_data      (bram_data),
        .bram_cs        (bram_cs),
        .bram_wr        (bram_wr),
        .busy           (busy),
        .load_done      (load_done),
        .err_overflow   (err_overflow),
        .err_timeout    (err_timeout),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (sdr_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, sdr_req}, 32'd1);
    endtask

    task automatic pulse_rdy();
        sdr_rdy = 1'b1;
        tick();
        sdr_rdy = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick();
    endtask

    logic [24:0] a_bram;
    logic [15:0] exp_sum;
    int          n_tmo;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_eq("rst_wait", {31'd0, ioctl_wait}, 0);
        check_eq("rst_req", {31'd0, sdr_req}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_done", {31'd0, load_done}, 0);
        check_eq("rst_errs", {30'd0, err_overflow, err_timeout}, 0);
        check_eq("rst_bram", {25'd0, bram_wr, bram_cs}, 0);
        check_eq("rst_sum", {16'd0, checksum}, 0);

        // Full word 0x11@0, 0x22@1
        start_dl();
        check_eq("t1_busy", {31'd0, busy}, 1);
        strobe(25'd0, 8'h11);
        check_eq("t1_wait_lo", {31'd0, ioctl_wait}, 0);
        strobe(25'd1, 8'h22);
        check_eq("t1_wait_issue", {31'd0, ioctl_wait}, 1);
        check_eq("t1_req_early", {31'd0, sdr_req}, 0);
        tick();
        check_eq("t1_req", {31'd0, sdr_req}, 1);
        check_eq("t1_addr", {7'd0, sdr_addr}, 32'h0);
        check_eq("t1_data", {16'd0, sdr_data}, 32'h2211);
        check_eq("t1_be", {30'd0, sdr_be}, 3);
        tick();
        tick();
        check_eq("t1_req_hold", {31'd0, sdr_req}, 1);
        check_eq("t1_wait_hold", {31'd0, ioctl_wait}, 1);
        pulse_rdy();
        check_eq("t1_req_drop", {31'd0, sdr_req}, 0);
        check_eq("t1_wait_low", {31'd0, ioctl_wait}, 0);
        ioctl_download = 1'b0;
        tick();
        check_eq("t1_load_done", {31'd0, load_done}, 1);
        tick();
        check_eq("t1_done_pulse", {31'd0, load_done}, 0);
        check_eq("t1_idle", {31'd0, busy}, 0);

        // Two partial words 0xAA@4, 0xBB@8
        start_dl();
        strobe(25'd4, 8'hAA);
        strobe(25'd8, 8'hBB);
        check_eq("t2_wait_skid", {31'd0, ioctl_wait}, 1);
        tick();
        check_eq("t2_req1", {31'd0, sdr_req}, 1);
        check_eq("t2_addr1", {7'd0, sdr_addr}, 32'd4);
        check_eq("t2_data1", {24'd0, sdr_data[7:0]}, 32'hAA);
        check_eq("t2_be1", {30'd0, sdr_be}, 1);
        pulse_rdy();
        check_eq("t2_wait_skidfull", {31'd0, ioctl_wait}, 1);
        tick();
        check_eq("t2_wait_drained", {31'd0, ioctl_wait}, 0);
        ioctl_download = 1'b0;
        tick();
        wait_req("t2_req2");
        check_eq("t2_addr2", {7'd0, sdr_addr}, 32'd8);
        check_eq("t2_data2", {24'd0, sdr_data[7:0]}, 32'hBB);
        check_eq("t2_be2", {30'd0, sdr_be}, 1);
        pulse_rdy();
        check_eq("t2_load_done", {31'd0, load_done}, 1);
        check_eq("t2_no_ovf", {31'd0, err_overflow}, 0);
        tick();

        // BRAM byte, ignored index, out-of-map byte
        start_dl();
        a_bram = BRAM_START + 25'(2) * BRAM_CHIP_BYTES + 25'd3;
        strobe(a_bram, 8'h5A);
        check_eq("t3_wr", {31'd0, bram_wr}, 1);
        check_eq("t3_cs", {26'd0, bram_cs}, 32'b000100);
        check_eq("t3_addr", {12'd0, bram_addr}, 32'd3);
        check_eq("t3_data", {24'd0, bram_data}, 32'h5A);
        tick();
        check_eq("t3_wr_pulse", {31'd0, bram_wr}, 0);
        ioctl_index = 16'd1;
        strobe(a_bram, 8'h77);
        ioctl_index = 16'd0;
        check_eq("t3_index_ignored", {31'd0, bram_wr}, 0);
        check_eq("t3_index_no_ovf", {31'd0, err_overflow}, 0);
        strobe(25'h1FF0000, 8'h33);
        check_eq("t3_oom_ovf", {31'd0, err_overflow}, 1);
        check_eq("t3_oom_no_wr", {31'd0, bram_wr}, 0);
        ioctl_download = 1'b0;
        tick();
        check_eq("t3_load_done", {31'd0, load_done}, 1);
        tick();

        // Three strobes inside one WAIT_RDY
        start_dl();
        check_eq("t4_ovf_cleared", {31'd0, err_overflow}, 0);
        strobe(25'h10, 8'h01);
        strobe(25'h11, 8'h02);
        tick();
        check_eq("t4_req", {31'd0, sdr_req}, 1);
        strobe(25'h20, 8'hA0);
        check_eq("t4_first_in_skid", {31'd0, err_overflow}, 0);
        strobe(25'h21, 8'hA1);
        strobe(25'h22, 8'hA2);
        check_eq("t4_ovf", {31'd0, err_overflow}, 1);
        check_eq("t4_wait", {31'd0, ioctl_wait}, 1);
        pulse_rdy();
        tick();
        ioctl_download = 1'b0;
        tick();
        wait_req("t4_flush_req");
        check_eq("t4_flush_addr", {7'd0, sdr_addr}, 32'h20);
        check_eq("t4_flush_data", {24'd0, sdr_data[7:0]}, 32'hA0);
        check_eq("t4_flush_be", {30'd0, sdr_be}, 1);
        pulse_rdy();
        check_eq("t4_load_done", {31'd0, load_done}, 1);
        check_eq("t4_ovf_sticky", {31'd0, err_overflow}, 1);
        tick();

        // Timeout: rdy never comes
        start_dl();
        check_eq("t5_ovf_cleared", {31'd0, err_overflow}, 0);
        strobe(25'h30, 8'h01);
        strobe(25'h31, 8'h02);
        tick();
        n_tmo = 0;
        while (sdr_req === 1'b1 && n_tmo < 5000) begin
            n_tmo++;
            tick();
        end
        check_eq("t5_req_cycles", n_tmo, 4096);
        check_eq("t5_tmo", {31'd0, err_timeout}, 1);
        check_eq("t5_wait_low", {31'd0, ioctl_wait}, 0);
        strobe(BRAM_START + 25'd9, 8'h44);
        check_eq("t5_collect_again", {31'd0, bram_wr}, 1);
        ioctl_download = 1'b0;
        tick();
        check_eq("t5_load_done", {31'd0, load_done}, 1);
        tick();

        // Reset in the middle of WAIT_RDY
        start_dl();
        check_eq("t6_tmo_cleared", {31'd0, err_timeout}, 0);
        strobe(25'h40, 8'h01);
        strobe(25'h41, 8'h02);
        tick();
        check_eq("t6_req", {31'd0, sdr_req}, 1);
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick();
        check_eq("t6_req_dropped", {31'd0, sdr_req}, 0);
        check_eq("t6_wait", {31'd0, ioctl_wait}, 0);
        check_eq("t6_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        tick();

        // Checksum over FF, FF, 02
`ifdef ROM_CHECKSUM_EN
        exp_sum = 16'h0200;
`else
        exp_sum = 16'h0000;
`endif
        start_dl();
        strobe(BRAM_START + 25'd0, 8'hFF);
        strobe(BRAM_START + 25'd1, 8'hFF);
        strobe(BRAM_START + 25'd2, 8'h02);
        check_eq("t7_wr", {31'd0, bram_wr}, 1);
        check_eq("t7_cs", {26'd0, bram_cs}, 32'b000001);
        check_eq("t7_addr", {12'd0, bram_addr}, 32'd2);
        check_eq("t7_sum", {16'd0, checksum}, {16'd0, exp_sum});
        ioctl_download = 1'b0;
        tick();
        check_eq("t7_load_done", {31'd0, load_done}, 1);
        tick();
        check_eq("t7_sum_frozen", {16'd0, checksum}, {16'd0, exp_sum});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
